// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus an MMIO block
// with GPIO, a free-running cycle counter and a compare-match timer interrupt.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wen,
  input  logic        mem_ren,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  localparam logic [2:0] OFF_GPIO_OUT   = 3'd0;
  localparam logic [2:0] OFF_GPIO_IN    = 3'd1;
  localparam logic [2:0] OFF_CYCLE      = 3'd2;
  localparam logic [2:0] OFF_TIMER_CMP  = 3'd3;
  localparam logic [2:0] OFF_TIMER_STAT = 3'd4;

  logic          ram_sel;
  logic          mmio_sel;
  logic          mmio_wen;
  logic [AW-1:0] ram_idx;
  logic [2:0]    mmio_off;

  assign ram_sel  = (dmem_addr < RAM_BYTES);
  assign mmio_sel = (dmem_addr[31:5] == MMIO_BASE[31:5]);
  assign ram_idx  = dmem_addr[AW+1:2];
  assign mmio_off = dmem_addr[4:2];
  assign mmio_wen = mem_wen && mmio_sel;

  // RAM is deliberately outside the reset domain: a store in a reset cycle still lands.
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (mem_wen && ram_sel) begin
      mem[ram_idx] <= dmem_wdata;
    end
  end

  logic [7:0]  gpio_out_reg;
  logic [7:0]  sync_meta_reg;
  logic [7:0]  sync_reg;
  logic [31:0] cycle_reg;
  logic [31:0] timer_cmp_reg;
  logic        irq_reg;
  logic        irq_clear;

  assign irq_clear = mmio_wen && (mmio_off == OFF_TIMER_STAT) && dmem_wdata[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_reg  <= 8'd0;
      cycle_reg     <= 32'd0;
      timer_cmp_reg <= 32'hFFFF_FFFF;
      irq_reg       <= 1'b0;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
      if (mmio_wen && (mmio_off == OFF_GPIO_OUT)) begin
        gpio_out_reg <= dmem_wdata[7:0];
      end
      if (mmio_wen && (mmio_off == OFF_TIMER_CMP)) begin
        timer_cmp_reg <= dmem_wdata;
      end
      // A match on the same edge as a clear keeps the flag set.
      if (cycle_reg == timer_cmp_reg) begin
        irq_reg <= 1'b1;
      end else if (irq_clear) begin
        irq_reg <= 1'b0;
      end
    end
  end

  // Two-flop synchronizer, one pair per external input bit.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_meta_reg[gi] <= 1'b0;
          sync_reg[gi]      <= 1'b0;
        end else begin
          sync_meta_reg[gi] <= gpio_in[gi];
          sync_reg[gi]      <= sync_meta_reg[gi];
        end
      end
    end
  endgenerate

  logic [31:0] rdata_next;

  always_comb begin
    rdata_next = 32'd0;
    if (mem_ren) begin
      if (ram_sel) begin
        rdata_next = mem[ram_idx];
      end else if (mmio_sel) begin
        case (mmio_off)
          OFF_GPIO_OUT:   rdata_next = {24'd0, gpio_out_reg};
          OFF_GPIO_IN:    rdata_next = {24'd0, sync_reg};
          OFF_CYCLE:      rdata_next = cycle_reg;
          OFF_TIMER_CMP:  rdata_next = timer_cmp_reg;
          OFF_TIMER_STAT: rdata_next = {31'd0, irq_reg};
          default:        rdata_next = 32'd0;
        endcase
      end
    end
  end

  assign dmem_rdata = rdata_next;
  assign gpio_out   = gpio_out_reg;
  assign timer_irq  = irq_reg;

endmodule
